// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions and the fetch FSM states.
package isa_pkg;

  localparam logic [5:0] OP_SUMA  = 6'b000001;
  localparam logic [5:0] OP_RESTA = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int DEST_HI = 24;
  localparam int DEST_LO = 22;
  localparam int R1_HI   = 21;
  localparam int R1_LO   = 19;
  localparam int R2_HI   = 18;
  localparam int R2_LO   = 16;
  localparam int I1_HI   = 15;
  localparam int I1_LO   = 8;
  localparam int I2_HI   = 7;
  localparam int I2_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding {instr, pc} pairs between instruction memory and the decoder.
module fetch_skid_buf #(
  parameter int DATA_W = 42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem[gi] <= '0;
        end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  // A flush wins over a simultaneous push: the arriving word belongs to a squashed request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign occupancy = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and
// hands instructions to the decoder through a 2-entry skid buffer with valid/ready.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  localparam int BUF_W = INSTR_W + ADDR_W;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;

  logic              pop, halt_pop, issue, flush, push;
  logic [1:0]        occupancy;
  logic [2:0]        load;
  logic [BUF_W-1:0]  head_data;

  fetch_skid_buf #(.DATA_W(BUF_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, inflight_pc_reg}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  assign out_valid = (occupancy != 2'd0);
  assign out_instr = head_data[BUF_W-1:ADDR_W];
  assign out_pc    = head_data[ADDR_W-1:0];
  assign halted    = (state_reg == HALT);
  assign imem_req  = issue;
  assign imem_addr = pc_reg;

  // Buffered plus in-flight words, used to guarantee every response finds a free slot.
  assign load = 3'(occupancy) + 3'(inflight_reg);
  assign push = inflight_reg && !flush;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    issue      = 1'b0;
    flush      = 1'b0;
    pop        = out_valid && out_ready;
    halt_pop   = pop && (out_instr[OPC_HI:OPC_LO] == OP_HALT);

    case (state_reg)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (halt_pop) begin
          state_next = HALT;
          flush      = 1'b1;
        end else if ((load - 3'(pop)) < 3'd2) begin
          issue = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase

    // Redirect overrides everything, including a halt popped in the same cycle.
    if (redirect_valid) begin
      state_next = FETCH;
      pc_next    = redirect_pc;
      flush      = 1'b1;
      issue      = 1'b0;
    end else if (issue) begin
      pc_next = pc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= ADDR_W'(RESET_PC);
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr}, monitors compare on handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        halted;

  logic        imem_req_w;
  logic [3:0]  imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [31:0] out_instr_w;
  logic [3:0]  out_pc_w;
  logic        halted_w;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_w_q[$];
  logic [31:0] rom [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );

  fetch_unit #(.ADDR_W(4), .INSTR_W(32), .RESET_PC(14)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .redirect_valid(1'b0), .redirect_pc(4'd0),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_instr(out_instr_w), .out_pc(out_pc_w), .halted(halted_w)
  );

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= rom[imem_addr];
    if (imem_req_w) imem_rdata_w <= 32'h0400_0000 | 32'(imem_addr_w);
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      delivered = delivered + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL deliver_unexpected: got pc=%0h instr=%h, none expected", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors = errors + 1;
          $display("FAIL deliver: got pc=%0h instr=%h, expected pc=%0h instr=%h",
                   out_pc, out_instr, e.pc, e.instr);
        end else begin
          $display("deliver pc=%0h instr=%h ok", out_pc, out_instr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_w && out_ready_w) begin
      checks = checks + 1;
      if (exp_w_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL wrap_unexpected: got pc=%0h instr=%h, none expected", out_pc_w, out_instr_w);
      end else begin
        exp_t e;
        e = exp_w_q.pop_front();
        if (10'(out_pc_w) !== e.pc || out_instr_w !== e.instr) begin
          errors = errors + 1;
          $display("FAIL wrap_deliver: got pc=%0h instr=%h, expected pc=%0h instr=%h",
                   out_pc_w, out_instr_w, e.pc, e.instr);
        end else begin
          $display("wrap deliver pc=%0h instr=%h ok", out_pc_w, out_instr_w);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end else begin
      $display("check %s = %h ok", name, actual);
    end
  endtask

  task automatic push_exp(input logic [9:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic push_exp_w(input logic [9:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_w_q.push_back(e);
  endtask

  task automatic wait_empty(input bit wrap, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (wrap ? (exp_w_q.size() == 0) : (exp_q.size() == 0)) return;
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL drain_timeout: %0d entries left, expected 0",
             wrap ? exp_w_q.size() : exp_q.size());
    if (wrap) exp_w_q.delete(); else exp_q.delete();
  endtask

  task automatic measure_latency(input string name);
    int t_req = -1000;
    int t_v = 0;
    logic [9:0] first_addr = '1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && t_req < 0) begin
        t_req = cyc;
        first_addr = imem_addr;
      end
      if (out_valid) begin
        t_v = cyc;
        break;
      end
    end
    check({name, "_first_addr"}, 32'(first_addr), 32'h0);
    check({name, "_latency"}, 32'(t_v - t_req), 32'd2);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = 32'h0400_0000 | 32'(a);
    rom[0] = 32'h0400_0001;
    rom[1] = 32'h0800_0002;
    rom[2] = 32'h0400_0003;
    rom[3] = 32'h0800_0004;
    rom[5] = 32'hFC00_0000;

    rst = 1'b1;
    out_ready = 1'b0;
    out_ready_w = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rdata = '0;
    imem_rdata_w = '0;

    #2;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_wrap_imem_addr", 32'(imem_addr_w), 32'd14);

    // Free run through the halt word, with a 3-cycle stall after two deliveries.
    repeat (2) @(posedge clk);
    push_exp(10'd0, 32'h0400_0001);
    push_exp(10'd1, 32'h0800_0002);
    push_exp(10'd2, 32'h0400_0003);
    push_exp(10'd3, 32'h0800_0004);
    push_exp(10'd4, 32'h0400_0004);
    push_exp(10'd5, 32'hFC00_0000);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    measure_latency("start");

    for (int i = 0; i < 20 && delivered < 2; i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", 32'(out_pc), 32'd2);
      check("stall_instr", out_instr, 32'h0400_0003);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty(1'b0, 40);
    repeat (2) @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_valid", 32'(out_valid), 32'd0);

    // PC wrap in the 4-bit instance.
    push_exp_w(10'd14, 32'h0400_000E);
    push_exp_w(10'd15, 32'h0400_000F);
    push_exp_w(10'd0,  32'h0400_0000);
    push_exp_w(10'd1,  32'h0400_0001);
    @(posedge clk);
    #1;
    out_ready_w = 1'b1;
    wait_empty(1'b1, 40);
    out_ready_w = 1'b0;

    // Leave HALT by redirecting to 0; the run halts again at 5.
    push_exp(10'd0, 32'h0400_0001);
    push_exp(10'd1, 32'h0800_0002);
    push_exp(10'd2, 32'h0400_0003);
    push_exp(10'd3, 32'h0800_0004);
    push_exp(10'd4, 32'h0400_0004);
    push_exp(10'd5, 32'hFC00_0000);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    wait_empty(1'b0, 40);
    repeat (2) @(negedge clk);
    check("rehalt_halted", 32'(halted), 32'd1);

    // Redirect to 0x040 while the request for address 0 is in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 10'd0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("pre_redir_req", 32'(imem_req), 32'd1);
    check("pre_redir_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h040;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    push_exp(10'h040, 32'h0400_0040);
    push_exp(10'h041, 32'h0400_0041);
    push_exp(10'h042, 32'h0400_0042);
    push_exp(10'h043, 32'h0400_0043);
    @(negedge clk);
    check("redir_valid_low", 32'(out_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h040);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty(1'b0, 40);
    out_ready = 1'b0;

    // Asynchronous reset between clock edges with a full buffer.
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_req", 32'(imem_req), 32'd0);
    check("async_halted", 32'(halted), 32'd0);
    check("async_pc", 32'(out_pc), 32'd0);
    repeat (2) @(posedge clk);
    push_exp(10'd0, 32'h0400_0001);
    push_exp(10'd1, 32'h0800_0002);
    push_exp(10'd2, 32'h0400_0003);
    push_exp(10'd3, 32'h0800_0004);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    measure_latency("restart");
    wait_empty(1'b0, 40);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
